// File: rtl/vga_display_scaler.sv
// Purpose: fetch a small image from frame memory and show it upscaled at a fixed screen origin.
// Latency: frame_addr one clk after a new_pxl strobe; colour and syncs one pixel period (next strobe + 1 clk).
// Backpressure: none; every register advances only on new_pxl and the memory must answer before the next strobe.
module vga_display_scaler #(
    parameter int          c_img_cols     = 80,
    parameter int          c_img_rows     = 60,
    parameter int          c_nb_img_pxls  = 13,
    parameter int          c_nb_buf_red   = 4,
    parameter int          c_nb_buf_green = 4,
    parameter int          c_nb_buf_blue  = 4,
    parameter int          c_nb_buf       = 12,
    parameter int          c_scale        = 4,
    parameter int          c_x0           = 0,
    parameter int          c_y0           = 0,
    parameter logic [11:0] c_bg           = 12'h154,
    parameter int          c_mem_lat      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     visible,
    input  logic                     new_pxl,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic [1:0]               mode,
    input  logic [9:0]               col,
    input  logic [9:0]               row,
    input  logic [c_nb_buf-1:0]      frame_pixel,
    output logic [c_nb_img_pxls-1:0] frame_addr,
    output logic [3:0]               vga_red,
    output logic [3:0]               vga_green,
    output logic [3:0]               vga_blue,
    output logic                     hsync_o,
    output logic                     vsync_o
);

    typedef enum logic [1:0] {
        MODE_RGB   = 2'b00,
        MODE_GRAY  = 2'b01,
        MODE_MONO  = 2'b10,
        MODE_BLANK = 2'b11
    } mode_e;

    // Window geometry in 11-bit unsigned arithmetic.
    localparam logic [10:0] X0     = 11'(c_x0);
    localparam logic [10:0] Y0     = 11'(c_y0);
    localparam logic [10:0] X_SPAN = 11'(c_img_cols * c_scale);
    localparam logic [10:0] Y_SPAN = 11'(c_img_rows * c_scale);
    localparam logic [2:0]  SC_MAX = 3'(c_scale - 1);
    localparam logic [c_nb_img_pxls-1:0] LINE_STEP = c_nb_img_pxls'(c_img_cols);
    localparam logic [c_nb_img_pxls-1:0] ADDR_ONE  = c_nb_img_pxls'(1);

    // The memory latency only limits how close strobes may be; no logic depends on it.
    if (c_mem_lat < 1) begin : g_mem_lat_zero
    end

    // Address generator state.
    logic [c_nb_img_pxls-1:0] frame_addr_q, frame_addr_d;
    logic [c_nb_img_pxls-1:0] line_base_q, line_base_d;
    logic [2:0]               hcnt_q, hcnt_d;
    logic [2:0]               vcnt_q, vcnt_d;

    // One-pixel pipeline and output registers.
    logic        vis_dly_q, win_dly_q, hs_dly_q, vs_dly_q;
    mode_e       mode_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q;

    // Offsets from the origin: coordinates left of/above it wrap to large
    // values, so one unsigned compare against the span tests both bounds.
    logic [10:0] rel_col, rel_row;
    logic        in_col, in_row, col_first, col_last;

    assign rel_col   = {1'b0, col} - X0;
    assign rel_row   = {1'b0, row} - Y0;
    assign in_col    = rel_col < X_SPAN;
    assign in_row    = rel_row < Y_SPAN;
    assign col_first = rel_col == 11'd0;
    assign col_last  = rel_col == X_SPAN - 11'd1;

    // Next address: step through the image with counters instead of a divider.
    always_comb begin
        frame_addr_d = frame_addr_q;
        line_base_d  = line_base_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        if (!in_row) begin
            line_base_d  = '0;
            vcnt_d       = '0;
            frame_addr_d = '0;
        end else if (in_col) begin
            if (col_first) begin
                frame_addr_d = line_base_q;
                hcnt_d       = '0;
            end else if (hcnt_q == SC_MAX) begin
                hcnt_d       = '0;
                frame_addr_d = frame_addr_q + ADDR_ONE;
            end else begin
                hcnt_d = hcnt_q + 3'd1;
            end
            if (col_last) begin
                if (vcnt_q == SC_MAX) begin
                    vcnt_d      = '0;
                    line_base_d = line_base_q + LINE_STEP;
                end else begin
                    vcnt_d = vcnt_q + 3'd1;
                end
            end
        end
    end

    // Colour for the pixel strobed one period ago, using the word fetched for it.
    always_comb begin
        rgb_d = 12'h000;
        if (!vis_dly_q) begin
            rgb_d = 12'h000;
        end else if (!win_dly_q) begin
            rgb_d = c_bg;
        end else begin
            case (mode_q)
                MODE_RGB:   rgb_d = {frame_pixel[c_nb_buf_blue + c_nb_buf_green + c_nb_buf_red - 1 -: 4],
                                     frame_pixel[c_nb_buf_blue + c_nb_buf_green - 1 -: 4],
                                     frame_pixel[c_nb_buf_blue - 1 -: 4]};
                MODE_GRAY:  rgb_d = {frame_pixel[7:4], frame_pixel[7:4], frame_pixel[7:4]};
                MODE_MONO:  rgb_d = frame_pixel[7] ? 12'hfff : 12'h000;
                MODE_BLANK: rgb_d = c_bg;
            endcase
        end
    end

    // Address counters advance once per screen pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_addr_q <= '0;
            line_base_q  <= '0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
        end else if (new_pxl) begin
            frame_addr_q <= frame_addr_d;
            line_base_q  <= line_base_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
        end
    end

    // Pixel pipeline, outputs, and frame-synchronous mode latch (on vsync falling).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis_dly_q <= 1'b0;
            win_dly_q <= 1'b0;
            hs_dly_q  <= 1'b1;
            vs_dly_q  <= 1'b1;
            mode_q    <= MODE_RGB;
            rgb_q     <= 12'h000;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else if (new_pxl) begin
            vis_dly_q <= visible;
            win_dly_q <= in_row && in_col;
            hs_dly_q  <= hsync;
            vs_dly_q  <= vsync;
            rgb_q     <= rgb_d;
            hsync_q   <= hs_dly_q;
            vsync_q   <= vs_dly_q;
            if (vs_dly_q && !vsync) begin
                mode_q <= mode_e'(mode);
            end
        end
    end

    assign frame_addr = frame_addr_q;
    assign vga_red    = rgb_q[11:8];
    assign vga_green  = rgb_q[7:4];
    assign vga_blue   = rgb_q[3:0];
    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;

endmodule

// File: tb/tb_vga_display_scaler.sv
// Bench for vga_display_scaler: two instances (offset origin scale 2, zero origin scale 3)
// driven by a shrunk raster with random strobe spacing; expectations come from a
// per-pixel divide/modulo model of the image window and a per-frame mode model.
module tb_vga_display_scaler;
    localparam int H_TOT = 32, H_VIS = 28, V_TOT = 20, V_VIS = 18, N_FRAMES = 6;
    localparam int A_COLS = 10, A_ROWS = 6, A_S = 2, A_X0 = 5, A_Y0 = 3;
    localparam int B_COLS = 8,  B_ROWS = 5, B_S = 3, B_X0 = 0, B_Y0 = 0;
    localparam logic [11:0] A_BG = 12'h154, B_BG = 12'h0a5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       visible = 1'b0, new_pxl = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [9:0] col = '0, row = '0;
    logic [11:0] pix_a, pix_b;
    logic [5:0]  addr_a, addr_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, hs_b, vs_b;
    logic [11:0] img_a [64];
    logic [11:0] img_b [64];

    always #5 clk = ~clk;

    vga_display_scaler #(
        .c_img_cols(A_COLS), .c_img_rows(A_ROWS), .c_nb_img_pxls(6),
        .c_nb_buf_red(4), .c_nb_buf_green(4), .c_nb_buf_blue(4), .c_nb_buf(12),
        .c_scale(A_S), .c_x0(A_X0), .c_y0(A_Y0), .c_bg(A_BG), .c_mem_lat(1)
    ) u_a (
        .clk(clk), .rst(rst), .visible(visible), .new_pxl(new_pxl),
        .hsync(hsync), .vsync(vsync), .mode(mode), .col(col), .row(row),
        .frame_pixel(pix_a), .frame_addr(addr_a),
        .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
        .hsync_o(hs_a), .vsync_o(vs_a)
    );

    vga_display_scaler #(
        .c_img_cols(B_COLS), .c_img_rows(B_ROWS), .c_nb_img_pxls(6),
        .c_nb_buf_red(4), .c_nb_buf_green(4), .c_nb_buf_blue(4), .c_nb_buf(12),
        .c_scale(B_S), .c_x0(B_X0), .c_y0(B_Y0), .c_bg(B_BG), .c_mem_lat(1)
    ) u_b (
        .clk(clk), .rst(rst), .visible(visible), .new_pxl(new_pxl),
        .hsync(hsync), .vsync(vsync), .mode(mode), .col(col), .row(row),
        .frame_pixel(pix_b), .frame_addr(addr_b),
        .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
        .hsync_o(hs_b), .vsync_o(vs_b)
    );

    // Frame memories with one clk of read latency.
    always @(posedge clk) begin
        pix_a <= img_a[addr_a];
        pix_b <= img_b[addr_b];
    end

    // Reference model state.
    int          p_x0[2]   = '{A_X0, B_X0};
    int          p_y0[2]   = '{A_Y0, B_Y0};
    int          p_s[2]    = '{A_S, B_S};
    int          p_cols[2] = '{A_COLS, B_COLS};
    int          p_rows[2] = '{A_ROWS, B_ROWS};
    logic [11:0] p_bg[2]   = '{A_BG, B_BG};
    int          exp_addr[2];
    logic [11:0] pend_rgb[2];
    logic        pend_hs, pend_vs, prev_vs;
    int          frame_mode;
    bit          in_sync;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] shade(input logic vis, input logic inw, input int m,
                                          input logic [11:0] w, input logic [11:0] bg);
        if (!vis) return 12'h000;
        if (!inw) return bg;
        case (m)
            0:       return w;
            1:       return {w[7:4], w[7:4], w[7:4]};
            2:       return (w[7:4] >= 4'd8) ? 12'hfff : 12'h000;
            default: return bg;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_addr[d] = 0;
            pend_rgb[d] = 12'h000;
        end
        pend_hs    = 1'b1;
        pend_vs    = 1'b1;
        prev_vs    = 1'b1;
        frame_mode = 0;
    endtask

    task automatic check_reset_values();
        chk("rst A addr", 32'(addr_a), 32'd0);
        chk("rst B addr", 32'(addr_b), 32'd0);
        chk("rst A rgb", 32'({r_a, g_a, b_a}), 32'd0);
        chk("rst B rgb", 32'({r_b, g_b, b_b}), 32'd0);
        chk("rst A hsync_o", 32'(hs_a), 32'd1);
        chk("rst A vsync_o", 32'(vs_a), 32'd1);
        chk("rst B hsync_o", 32'(hs_b), 32'd1);
        chk("rst B vsync_o", 32'(vs_b), 32'd1);
    endtask

    // Entered and left at posedge+1.
    task automatic strobe(input int c, input int r, input logic [1:0] m);
        logic        vis, hs_in, vs_in, inr, inc;
        logic [11:0] word, obs_rgb;
        logic [11:0] new_rgb[2];
        int          obs_addr;
        vis   = (c < H_VIS) && (r < V_VIS);
        hs_in = !(c == 29 || c == 30);
        vs_in = !(r == V_TOT - 1);
        col = 10'(c); row = 10'(r); visible = vis; hsync = hs_in; vsync = vs_in; mode = m;
        new_pxl = 1'b1;
        @(posedge clk);
        #1;
        new_pxl = 1'b0;
        if (r == V_TOT - 1) in_sync = 1'b1;
        if (prev_vs && !vs_in) frame_mode = int'(m);
        prev_vs = vs_in;
        for (int d = 0; d < 2; d++) begin
            inr = (r >= p_y0[d]) && (r < p_y0[d] + p_rows[d] * p_s[d]);
            inc = (c >= p_x0[d]) && (c < p_x0[d] + p_cols[d] * p_s[d]);
            if (!inr) exp_addr[d] = 0;
            else if (inc) exp_addr[d] = ((r - p_y0[d]) / p_s[d]) * p_cols[d] + (c - p_x0[d]) / p_s[d];
            word = (d == 0) ? img_a[exp_addr[d]] : img_b[exp_addr[d]];
            new_rgb[d] = shade(vis, inr && inc, frame_mode, word, p_bg[d]);
            obs_addr = (d == 0) ? int'(addr_a) : int'(addr_b);
            obs_rgb  = (d == 0) ? {r_a, g_a, b_a} : {r_b, g_b, b_b};
            if (in_sync) begin
                chk($sformatf("%s addr (%0d,%0d)", d == 0 ? "A" : "B", c, r), 32'(obs_addr), 32'(exp_addr[d]));
                chk($sformatf("%s rgb (%0d,%0d)", d == 0 ? "A" : "B", c, r), 32'(obs_rgb), 32'(pend_rgb[d]));
            end
        end
        chk($sformatf("A hsync_o (%0d,%0d)", c, r), 32'(hs_a), 32'(pend_hs));
        chk($sformatf("A vsync_o (%0d,%0d)", c, r), 32'(vs_a), 32'(pend_vs));
        chk($sformatf("B hsync_o (%0d,%0d)", c, r), 32'(hs_b), 32'(pend_hs));
        chk($sformatf("B vsync_o (%0d,%0d)", c, r), 32'(vs_b), 32'(pend_vs));
        pend_rgb[0] = new_rgb[0];
        pend_rgb[1] = new_rgb[1];
        pend_hs = hs_in;
        pend_vs = vs_in;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            img_a[i] = 12'($urandom);
            img_b[i] = 12'($urandom);
        end
        img_a[0] = 12'h080;
        img_a[1] = 12'h070;

        // Power-up reset.
        rst = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        in_sync = 1'b1;

        // Frames: mode input is random mid-frame and a fixed sequence during vsync.
        for (int f = 0; f < N_FRAMES; f++) begin
            for (int r = 0; r < V_TOT; r++) begin
                for (int c = 0; c < H_TOT; c++) begin
                    if (f == 3 && r == 10 && c == 13) begin
                        rst = 1'b1;
                        #1;
                        check_reset_values();
                        repeat (3) @(posedge clk);
                        #1;
                        rst = 1'b0;
                        model_reset();
                        in_sync = 1'b0;
                    end
                    strobe(c, r, (r == V_TOT - 1) ? 2'(f + 1) : 2'($urandom_range(0, 3)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_display_scaler.md
# vga_display_scaler

Parametrised successor of the framebuffer-to-VGA display stage. It reads a small image from the frame memory and shows it on screen with integer upscaling and a programmable origin. The frame-memory read latency is absorbed by a one-pixel output pipeline, and the colour mode switches only on frame boundaries. It sits between the VGA sync generator (col/row/visible/new_pxl/hsync/vsync) and the VGA pins, with frame_addr/frame_pixel going to the frame buffer read port.

## Interface
- c_img_cols, 80: image width in pixels
- c_img_rows, 60: image height in pixels
- c_nb_img_pxls, 13: frame_addr width; 2^13 ≥ 80*60
- c_nb_buf_red / c_nb_buf_green / c_nb_buf_blue, 4/4/4: colour field widths in a memory word
- c_nb_buf, 12: memory word width, equal to the sum of the three fields
- c_scale, 4: integer upscale factor, 1..8; each image pixel covers c_scale×c_scale screen pixels
- c_x0 / c_y0, 0/0: screen column/row of the image's top-left corner; c_x0+c_img_cols*c_scale ≤ 640 and c_y0+c_img_rows*c_scale ≤ 480
- c_bg, 12'h154: colour (R,G,B nibbles) for visible pixels outside the image window
- c_mem_lat, 1: frame-memory read latency in clk cycles; must be less than the new_pxl period
- clk  in  1  FPGA clock
- rst  in  1  reset, asynchronous, active high
- visible  in  1  screen pixel is in the active area
- new_pxl  in  1  one-clk strobe at each screen-pixel boundary
- hsync, vsync  in  1 each  syncs from the generator, active low
- mode  in  2  00 RGB, 01 gray, 10 threshold mono, 11 blank
- col, row  in  10 each  current screen coordinates
- frame_pixel  in  c_nb_buf  memory read data
- frame_addr  out  c_nb_img_pxls  memory read address, registered
- vga_red, vga_green, vga_blue  out  4 each  registered colour outputs
- hsync_o, vsync_o  out  1 each  syncs delayed to align with the colour outputs

## Operation
- The window is col in [c_x0, c_x0+c_img_cols*c_scale) and row in [c_y0, c_y0+c_img_rows*c_scale). All comparisons use 11-bit unsigned arithmetic.
- No multipliers or dividers. Address generation uses the following registers:
  - line_base: address of the current image row
  - hcnt / vcnt: 0..c_scale-1
  - addr: current address
- All of these registers update only on cycles where new_pxl=1:
  - Row outside window: line_base←0, vcnt←0, frame_addr←0.
  - col==c_x0 with row in window: frame_addr←line_base, hcnt←0.
  - Other in-window col: hcnt wraps at c_scale-1. frame_addr increments when hcnt wraps.
  - Last in-window col of a row: if vcnt==c_scale-1, then vcnt←0 and line_base←line_base+c_img_cols; otherwise vcnt++.
  - Col outside window in a window row: frame_addr and hcnt hold.
- Invariant: in window, frame_addr = ((row-c_y0)/c_scale)*c_img_cols + (col-c_x0)/c_scale. The address never exceeds c_img_cols*c_img_rows-1.
- Pipeline stage registers, loaded at each strobe: vis_d, win_d, hs_d, vs_d, together with the address.
- Colour for the pixel strobed at strobe k is produced at strobe k+1 from the frame_pixel value present then:
  - !vis_d → 0,0,0
  - !win_d → c_bg
  - mode 00 → the three colour fields
  - mode 01 → frame_pixel[7:4] on all three channels
  - mode 10 → 4'hF on all channels if frame_pixel[7:4] ≥ 8, else 0
  - mode 11 → c_bg
- Mode register (mode_r) loads the mode input only on a vsync 1→0 transition, detected with a registered vsync. A mid-frame change of mode takes effect from the next frame.

## Timing
- Reset values:
  - frame_addr=0; colours=0; hsync_o=vsync_o=1
  - mode_r=00; line_base=hcnt=vcnt=0; all pipeline registers 0, except hs_d and vs_d, which reset to 1
- Address latency: frame_addr is valid one clk after the new_pxl strobe for (col,row). frame_pixel must be stable c_mem_lat clks later, before the next strobe.
- Pixel latency: colour and hsync_o/vsync_o lag their inputs by exactly one pixel period. They update one clk after the strobe.
- When new_pxl=0, all registers hold.
- rst mid-line forces the reset values immediately. Correct addressing resumes at the next row entering the window. The first in-window row after reset starts at address 0 only if the window is re-entered from the top; otherwise addressing restarts cleanly from the next frame.
- Last pixel of the last window row: line_base may step to c_img_cols*c_img_rows. It is cleared when the next row falls outside the window, and is never driven onto frame_addr.
- If a vsync edge coincides with new_pxl, the mode load and the pipeline step both occur.

## Test plan
- c_scale=1, c_x0=c_y0=0; 640×480 timing, new_pxl every 4 clk, memory model with c_mem_lat=2 returning data = address -> frame_addr runs 0..4799 in raster order; pixel (5,2) shows RGB of word 165 one pixel later.
- c_scale=4 -> frame_addr for screen (0..3,0..3) = 0; for (4,0) = 1; for (0,4) = 80; for (319,239) = 4799; pixels at col 320..639 = c_bg.
- c_x0=100, c_y0=50, c_scale=2 -> screen (99,50) = c_bg; (100,50) addr 0; (102,52) addr 81; !visible region outputs 0,0,0.
- mode toggled 00→01 at row 200 -> rest of the frame stays RGB; gray from the frame after the vsync falling edge; mode 10 with word 12'h080 gives F,F,F; with 12'h070 gives 0,0,0.
- hsync/vsync alignment -> hsync_o falling edge is exactly one new_pxl period after the hsync falling edge.
- rst asserted at row 10, col 30 for 3 clk -> outputs go to reset values in the same cycle; the next frame's addresses match the first test.
